ahb_mem_slave: RTL
==================

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; power of two, at most 2^ADDR_W.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, wait states inserted per transfer; range 0..15.
REQ-005 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Trans  input  1  master requests a transfer this cycle.
REQ-008 SHALL have port AdressBus  input  ADDR_W  word address, sampled with Trans.
REQ-009 SHALL have port ReadWrite  input  1  0 = read, 1 = write, sampled with Trans.
REQ-010 SHALL have port MasterWriteBus  input  DATA_W  write data.
REQ-011 SHALL have port MasterReadBus  output  DATA_W  registered read data.
REQ-012 SHALL have port Ready  output  1  registered one-cycle transfer-complete pulse.

Function
REQ-013 SHALL implement a FSM with states IDLE (no pending transfer) and PEND (one captured transfer, wait counter active).
REQ-014 SHALL capture AdressBus and ReadWrite at a rising edge where Trans=1 and the FSM is in IDLE or is completing a transfer at that edge; it then enters PEND with counter = WAIT_CYCLES.
REQ-015 In PEND with counter>0, SHALL hold Ready=0 and decrement the counter by one each edge.
REQ-016 In PEND with counter=0, at the next edge SHALL complete the transfer and drive Ready=1 for exactly the following cycle.
REQ-017 On read completion, SHALL load MasterReadBus with mem[captured address]; MasterReadBus holds its value until the next read completes.
REQ-018 On write completion, SHALL write MasterWriteBus, sampled at the completing edge, into mem[captured address]; MasterReadBus is unchanged.
REQ-019 Latency: capture at edge N SHALL produce Ready=1 in the cycle after edge N+1+WAIT_CYCLES.
REQ-020 If Trans=1 at the completing edge, SHALL capture the next transfer at that same edge (back-to-back); with WAIT_CYCLES=0 sustained throughput is one transfer per cycle.
REQ-021 At the completing edge, if Trans=0 the FSM SHALL return to IDLE.
REQ-022 While in PEND with counter>0, SHALL ignore Trans; a deasserted Trans SHALL NOT cancel a captured transfer.
REQ-023 Read-after-write to the same address in consecutive transfers SHALL return the newly written data.
REQ-024 Memory index SHALL be the low log2(DEPTH) bits of the captured address unless AHB_SLV_ERR_EN is defined.

Reset
REQ-025 Rst=1 at an edge SHALL force IDLE, counter=0, Ready=0, MasterReadBus=0, and Error=0 when present.
REQ-026 Reset during PEND SHALL abort the transfer; no memory write occurs and no Ready pulse follows.
REQ-027 Reset SHALL NOT clear memory contents.
REQ-028 If Trans=1 in the first cycle after reset is released, SHALL capture it normally.

Configuration
REQ-029 Macro AHB_SLV_ERR_EN defined SHALL add port Error  output  1  registered, asserted together with Ready when the captured address >= DEPTH.
REQ-030 With AHB_SLV_ERR_EN defined, an erroring write SHALL be suppressed and an erroring read SHALL return 0 on MasterReadBus.
REQ-031 Without AHB_SLV_ERR_EN, the Error port SHALL be absent and out-of-range addresses wrap modulo DEPTH per REQ-024.

Verification
REQ-032 WAIT_CYCLES=0: write 0xBEEF to addr 5, then read addr 5 -> Ready=1 one cycle after each capture; read returns MasterReadBus=0xBEEF.
REQ-033 WAIT_CYCLES=3: single read of addr 7 (preloaded 0x1234) -> Ready=0 for 4 cycles after capture, then one-cycle Ready with MasterReadBus=0x1234.
REQ-034 WAIT_CYCLES=0, Trans held high for 4 writes to addrs 0..3 (data 0x11..0x44) then 4 reads -> 8 consecutive Ready cycles; reads return 0x11, 0x22, 0x33, 0x44.
REQ-035 WAIT_CYCLES=2: assert Rst one cycle after capturing a write of 0xAAAA to addr 9 (old value 0x0000) -> no Ready, MasterReadBus=0; a later read of addr 9 returns 0x0000.
REQ-036 AHB_SLV_ERR_EN defined, DEPTH=1024: write 0x5555 to addr 1024, then read addr 0 (preloaded 0x0001) -> write completes with Ready=1 and Error=1, addr 0 still reads 0x0001 with Error=0; without the macro, the same sequence reads 0x5555.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_mem_slave
//   Single-port word-addressed memory slave with a simple request/ready
//   handshake. A transfer is captured when Trans is high and the slave is
//   idle or finishing the previous transfer. It waits WAIT_CYCLES edges and
//   then completes, pulsing Ready for one cycle. With WAIT_CYCLES=0 and Trans
//   held high, the slave sustains one transfer per cycle.
//
// Parameters
//   DATA_W      data bus width
//   ADDR_W      address bus width
//   DEPTH       number of memory words (power of two, <= 2**ADDR_W)
//   WAIT_CYCLES wait states per transfer (0..15)
//
// Ports
//   Clk            in   clock, all state changes on rising edge
//   Rst            in   synchronous active-high reset (memory is not cleared)
//   Trans          in   transfer request
//   AdressBus      in   word address, sampled with Trans
//   ReadWrite      in   0 = read, 1 = write, sampled with Trans
//   MasterWriteBus in   write data, sampled at the completing edge
//   MasterReadBus  out  registered read data, held until the next read
//   Ready          out  registered one-cycle completion pulse
//   Error          out  (only with AHB_SLV_ERR_EN) asserted with Ready when
//                       the captured address is >= DEPTH
//
// Build option
//   AHB_SLV_ERR_EN  defined: out-of-range addresses raise Error, writes are
//                   dropped and reads return 0.
//                   undefined: addresses wrap modulo DEPTH, no Error port.
// ---------------------------------------------------------------------------
module ahb_mem_slave #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Trans,
  input  logic [ADDR_W-1:0] AdressBus,
  input  logic              ReadWrite,
  input  logic [DATA_W-1:0] MasterWriteBus,
  output logic [DATA_W-1:0] MasterReadBus,
  output logic              Ready
`ifdef AHB_SLV_ERR_EN
  ,
  output logic              Error
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rw_q;
  logic              oor_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic completing;
  logic accept;
  logic wr_en;
  logic oor_d;

  // The transfer finishes on the edge where the wait counter has run out.
  assign completing = (state_q == PEND) && (cnt_q == 4'd0);
  // A new request is taken when idle or on the completing edge (back-to-back).
  assign accept     = Trans && ((state_q == IDLE) || completing);
  // Reset at the completing edge aborts the write.
  assign wr_en      = !Rst && completing && rw_q && !oor_q;

`ifdef AHB_SLV_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  assign oor_d = ({1'b0, AdressBus} >= DEPTH_EXT);
`else
  assign oor_d = 1'b0;
`endif

  // Upper address bits only matter for range checking; without it they are
  // intentionally dropped so addresses wrap modulo DEPTH.
  generate
    if (IDX_W < ADDR_W) begin : g_hi_addr
      logic unused_hi_addr;
      assign unused_hi_addr = ^AdressBus[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Memory write port kept free of reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[idx_q] <= MasterWriteBus;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= completing;

      if (completing && !rw_q) begin
        rdata_q <= oor_q ? '0 : mem[idx_q];
      end

      if (accept) begin
        state_q <= PEND;
        cnt_q   <= 4'(WAIT_CYCLES);
        idx_q   <= AdressBus[IDX_W-1:0];
        rw_q    <= ReadWrite;
        oor_q   <= oor_d;
      end else if (completing) begin
        state_q <= IDLE;
      end else if (state_q == PEND) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

`ifdef AHB_SLV_ERR_EN
  logic err_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= completing && oor_q;
    end
  end

  assign Error = err_q;
`endif

  assign MasterReadBus = rdata_q;
  assign Ready         = ready_q;

endmodule
